// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler driving NUM_CH OFF/ON/BLINK/BREATHE channels.
// Define LED_PATTERN_BREATHE_EN to build the PWM breathe datapath; otherwise mode 3 behaves as BLINK.
module led_pattern_gen #(
   parameter int                NUM_CH       = 4,
   parameter int                TICK_DIV     = 25000,
   parameter int                RATE_W       = 8,
   parameter logic [RATE_W-1:0] DEFAULT_RATE = RATE_W'(15),
   localparam int               CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [1:0]        wr_mode,
   input  logic [RATE_W-1:0] wr_rate,
   output logic              tick,
   output logic [NUM_CH-1:0] led
);

   localparam int PRE_W = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_t;

   logic [PRE_W-1:0]  pre_cnt;
   logic              tick_q;

   mode_t             mode_q  [NUM_CH];
   mode_t             mode_d  [NUM_CH];
   logic [RATE_W-1:0] rate_q  [NUM_CH];
   logic [RATE_W-1:0] rate_d  [NUM_CH];
   logic [RATE_W-1:0] cnt_q   [NUM_CH];
   logic [RATE_W-1:0] cnt_d   [NUM_CH];
   logic [NUM_CH-1:0] phase_q;
   logic [NUM_CH-1:0] phase_d;
   logic [NUM_CH-1:0] wr_sel;
   logic [NUM_CH-1:0] led_d;
   logic [NUM_CH-1:0] led_q;

`ifdef LED_PATTERN_BREATHE_EN
   logic [7:0]        duty_q  [NUM_CH];
   logic [7:0]        duty_d  [NUM_CH];
   logic [NUM_CH-1:0] dir_q;   // 1 = ramping down
   logic [NUM_CH-1:0] dir_d;
   logic [7:0]        pwm_cnt;
`endif

   // tick is registered, so it is high in the cycle after the prescaler reaches its last count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         tick_q  <= 1'b0;
      end else begin
         tick_q  <= (pre_cnt == PRE_LAST);
         pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
      end
   end

   assign tick = tick_q;

   // Out-of-range channel indices match no channel, so such writes are dropped.
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_sel[i] = wr_en && (32'(wr_ch) == 32'(i));
      end
   end

`ifdef LED_PATTERN_BREATHE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end
`endif

   // Channel state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            mode_q[i] <= MODE_OFF;
            rate_q[i] <= DEFAULT_RATE;
            cnt_q[i]  <= '0;
`ifdef LED_PATTERN_BREATHE_EN
            duty_q[i] <= '0;
`endif
         end
         phase_q <= '0;
`ifdef LED_PATTERN_BREATHE_EN
         dir_q   <= '0;
`endif
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            mode_q[i] <= mode_d[i];
            rate_q[i] <= rate_d[i];
            cnt_q[i]  <= cnt_d[i];
`ifdef LED_PATTERN_BREATHE_EN
            duty_q[i] <= duty_d[i];
`endif
         end
         phase_q <= phase_d;
`ifdef LED_PATTERN_BREATHE_EN
         dir_q   <= dir_d;
`endif
      end
   end

   // Next-state: a write takes priority over a coincident tick on the same channel.
   always_comb begin
      phase_d = phase_q;
`ifdef LED_PATTERN_BREATHE_EN
      dir_d   = dir_q;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
         mode_d[i] = mode_q[i];
         rate_d[i] = rate_q[i];
         cnt_d[i]  = cnt_q[i];
`ifdef LED_PATTERN_BREATHE_EN
         duty_d[i] = duty_q[i];
`endif
         if (wr_sel[i]) begin
            mode_d[i]  = mode_t'(wr_mode);
            rate_d[i]  = wr_rate;
            cnt_d[i]   = '0;
            phase_d[i] = 1'b0;
`ifdef LED_PATTERN_BREATHE_EN
            duty_d[i]  = '0;
            dir_d[i]   = 1'b0;
`endif
         end else if (tick_q) begin
            if (cnt_q[i] == rate_q[i]) begin
               cnt_d[i]   = '0;
               phase_d[i] = ~phase_q[i];
`ifdef LED_PATTERN_BREATHE_EN
               // At either end the step turns the ramp around instead of wrapping.
               if (!dir_q[i]) begin
                  if (duty_q[i] == 8'hff) dir_d[i] = 1'b1;
                  else                    duty_d[i] = duty_q[i] + 1'b1;
               end else begin
                  if (duty_q[i] == 8'h00) dir_d[i] = 1'b0;
                  else                    duty_d[i] = duty_q[i] - 1'b1;
               end
`endif
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Output decode, registered below
   always_comb begin
      led_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         case (mode_q[i])
            MODE_OFF:     led_d[i] = 1'b0;
            MODE_ON:      led_d[i] = 1'b1;
            MODE_BLINK:   led_d[i] = phase_q[i];
`ifdef LED_PATTERN_BREATHE_EN
            MODE_BREATHE: led_d[i] = (pwm_cnt < duty_q[i]);
`else
            MODE_BREATHE: led_d[i] = phase_q[i];
`endif
            default:      led_d[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q <= '0;
      end else begin
         led_q <= led_d;
      end
   end

   assign led = led_q;

endmodule
